// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - load/store memory stage with variable-latency request/ack port
module mem_access_stage #(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] rs2_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DWIDTH-1:0] load_data_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DWIDTH-1:0] mem_rdata_i
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int         CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_FUNCT3   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t state, state_next;

    logic [2:0]    funct3_q;
    logic [1:0]    off_q;
    logic [CW-1:0] cnt_q;

    logic              is_load, is_store, is_mem;
    logic              illegal, misaligned, mem_ok;
    logic [3:0]        be_next;
    logic [DWIDTH-1:0] wdata_next;
    logic [DWIDTH-1:0] fmt_data;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;

    // Request decode: funct3[1:0] is the access size for both loads and stores.
    always_comb begin
        is_load    = (opcode_i == OP_LOAD);
        is_store   = (opcode_i == OP_STORE);
        is_mem     = is_load || is_store;
        illegal    = 1'b0;
        if (is_load)
            illegal = (funct3_i[1:0] == 2'b11) || (funct3_i[2] && funct3_i[1]);
        else if (is_store)
            illegal = funct3_i[2] || (funct3_i[1:0] == 2'b11);
        misaligned = ((funct3_i[1:0] == 2'd1) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'd2) && (addr_i[1:0] != 2'b00));
        mem_ok     = is_mem && !illegal && !misaligned;

        be_next    = 4'b0000;
        wdata_next = '0;
        if (is_store) begin
            case (funct3_i[1:0])
                2'd0: begin
                    be_next    = 4'b0001 << addr_i[1:0];
                    wdata_next = {4{rs2_i[7:0]}};
                end
                2'd1: begin
                    be_next    = 4'b0011 << addr_i[1:0];
                    wdata_next = {2{rs2_i[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = rs2_i;
                end
            endcase
        end
    end

    // Load formatting from the latched size/sign and byte offset.
    always_comb begin
        rd_byte  = mem_rdata_i[8*off_q +: 8];
        rd_half  = mem_rdata_i[16*off_q[1] +: 16];
        fmt_data = '0;
        case (funct3_q)
            3'd0:    fmt_data = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    fmt_data = {{16{rd_half[15]}}, rd_half};
            3'd2:    fmt_data = mem_rdata_i;
            3'd4:    fmt_data = {24'd0, rd_byte};
            3'd5:    fmt_data = {16'd0, rd_half};
            default: fmt_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready_o    = 1'b0;
        mem_req_o  = 1'b0;
        case (state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (valid_i && mem_ok)
                    state_next = S_REQ;
            end
            S_REQ: begin
                mem_req_o = 1'b1;
                if (mem_ack_i || (cnt_q == CNT_MAX))
                    state_next = S_RESP;
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Completion results are registered so valid_o lands on the cycle after the deciding edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o     <= 1'b0;
            load_data_o <= '0;
            err_o       <= 1'b0;
            err_code_o  <= ERR_NONE;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= 4'b0000;
            mem_wdata_o <= '0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            cnt_q       <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        if (!is_mem || illegal || misaligned) begin
                            valid_o     <= 1'b1;
                            load_data_o <= '0;
                            err_o       <= is_mem;
                            err_code_o  <= !is_mem ? ERR_NONE :
                                           illegal ? ERR_FUNCT3 : ERR_MISALIGN;
                        end else begin
                            mem_we_o    <= is_store;
                            mem_addr_o  <= {addr_i[AWIDTH-1:2], 2'b00};
                            mem_be_o    <= be_next;
                            mem_wdata_o <= wdata_next;
                            funct3_q    <= funct3_i;
                            off_q       <= addr_i[1:0];
                            cnt_q       <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        valid_o     <= 1'b1;
                        err_o       <= 1'b0;
                        err_code_o  <= ERR_NONE;
                        load_data_o <= mem_we_o ? '0 : fmt_data;
                    end else if (cnt_q == CNT_MAX) begin
                        valid_o     <= 1'b1;
                        err_o       <= 1'b1;
                        err_code_o  <= ERR_TIMEOUT;
                        load_data_o <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed vector bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] rs2_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] load_data_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ALU   = 7'b0110011;
    localparam int NEVER = 1000;

    always #5 clk = ~clk;

    mem_access_stage #(.DWIDTH(32), .AWIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .opcode_i(opcode_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .rs2_i(rs2_i), .ready_o(ready_o),
        .valid_o(valid_o), .load_data_o(load_data_o), .err_o(err_o),
        .err_code_o(err_code_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          wait_n;
        int          exp_req;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_lat;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int reqs;
        int lat;
        @(negedge clk);
        chk({v.name, " ready"}, 32'(ready_o), 32'd1);
        valid_i     = 1'b1;
        opcode_i    = v.op;
        funct3_i    = v.f3;
        addr_i      = v.addr;
        rs2_i       = v.rs2;
        mem_rdata_i = v.rdata;
        @(negedge clk);
        valid_i = 1'b0;
        reqs = 0;
        lat  = -1;
        for (int c = 1; c <= 40; c++) begin
            if (mem_req_o) begin
                if (reqs == 0) begin
                    chk({v.name, " we"},   32'(mem_we_o), 32'(v.exp_we));
                    chk({v.name, " be"},   32'(mem_be_o), 32'(v.exp_be));
                    chk({v.name, " addr"}, mem_addr_o, v.exp_addr);
                    if (v.exp_we) chk({v.name, " wdata"}, mem_wdata_o, v.exp_wdata);
                end
                reqs++;
                mem_ack_i = (reqs == v.wait_n + 1);
            end else begin
                mem_ack_i = 1'b0;
            end
            if (valid_o) begin
                lat = c;
                chk({v.name, " err"},  32'(err_o), 32'(v.exp_err));
                chk({v.name, " code"}, 32'(err_code_o), 32'(v.exp_code));
                chk({v.name, " load"}, load_data_o, v.exp_load);
                break;
            end
            @(negedge clk);
        end
        mem_ack_i = 1'b0;
        chk({v.name, " latency"},  32'(lat),  32'(v.exp_lat));
        chk({v.name, " req_cycles"}, 32'(reqs), 32'(v.exp_req));
    endtask

    initial begin
        reset = 1'b1; valid_i = 1'b0; opcode_i = '0; funct3_i = '0; addr_i = '0;
        rs2_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;

        //            name        op     f3    addr          rs2           rdata        wait  req we be       addr          wdata        lat err code load
        vq.push_back('{"sw",      STORE, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        0,    1, 1, 4'b1111, 32'h100, 32'hDEADBEEF, 2,  0, 2'd0, 32'h0});
        vq.push_back('{"lb_wait", LOAD,  3'd0, 32'h203, 32'h0,        32'h80FF1234, 2,    3, 0, 4'b0000, 32'h200, 32'h0,        4,  0, 2'd0, 32'hFFFFFF80});
        vq.push_back('{"lhu",     LOAD,  3'd5, 32'h202, 32'h0,        32'h80FF1234, 1,    2, 0, 4'b0000, 32'h200, 32'h0,        3,  0, 2'd0, 32'h000080FF});
        vq.push_back('{"sb",      STORE, 3'd0, 32'h101, 32'hAB,       32'h0,        0,    1, 1, 4'b0010, 32'h100, 32'hABABABAB, 2,  0, 2'd0, 32'h0});
        vq.push_back('{"sh_hi",   STORE, 3'd1, 32'h102, 32'h12345678, 32'h0,        0,    1, 1, 4'b1100, 32'h100, 32'h56785678, 2,  0, 2'd0, 32'h0});
        vq.push_back('{"lh_neg",  LOAD,  3'd1, 32'h206, 32'h0,        32'hF00D5678, 0,    1, 0, 4'b0000, 32'h204, 32'h0,        2,  0, 2'd0, 32'hFFFFF00D});
        vq.push_back('{"lb_pos",  LOAD,  3'd0, 32'h200, 32'h0,        32'h0000007F, 0,    1, 0, 4'b0000, 32'h200, 32'h0,        2,  0, 2'd0, 32'h0000007F});
        vq.push_back('{"lbu",     LOAD,  3'd4, 32'h201, 32'h0,        32'h00009A00, 0,    1, 0, 4'b0000, 32'h200, 32'h0,        2,  0, 2'd0, 32'h0000009A});
        vq.push_back('{"lw",      LOAD,  3'd2, 32'h104, 32'h0,        32'hCAFEBABE, 0,    1, 0, 4'b0000, 32'h104, 32'h0,        2,  0, 2'd0, 32'hCAFEBABE});
        vq.push_back('{"lw_mis",  LOAD,  3'd2, 32'h102, 32'h0,        32'h0,        0,    0, 0, 4'b0000, 32'h0,   32'h0,        1,  1, 2'd1, 32'h0});
        vq.push_back('{"sh_mis",  STORE, 3'd1, 32'h101, 32'h0,        32'h0,        0,    0, 0, 4'b0000, 32'h0,   32'h0,        1,  1, 2'd1, 32'h0});
        vq.push_back('{"ld_f3",   LOAD,  3'd3, 32'h100, 32'h0,        32'h0,        0,    0, 0, 4'b0000, 32'h0,   32'h0,        1,  1, 2'd2, 32'h0});
        vq.push_back('{"st_f3",   STORE, 3'd4, 32'h101, 32'h0,        32'h0,        0,    0, 0, 4'b0000, 32'h0,   32'h0,        1,  1, 2'd2, 32'h0});
        vq.push_back('{"add",     ALU,   3'd0, 32'h0,   32'h0,        32'h0,        0,    0, 0, 4'b0000, 32'h0,   32'h0,        1,  0, 2'd0, 32'h0});
        vq.push_back('{"lw_tmo",  LOAD,  3'd2, 32'h300, 32'h0,        32'h12345678, NEVER,16, 0, 4'b0000, 32'h300, 32'h0,        17, 1, 2'd3, 32'h0});

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst ready", 32'(ready_o), 32'd1);
        chk("rst valid", 32'(valid_o), 32'd0);
        chk("rst req",   32'(mem_req_o), 32'd0);
        chk("rst we",    32'(mem_we_o), 32'd0);
        chk("rst be",    32'(mem_be_o), 32'd0);
        chk("rst addr",  mem_addr_o, 32'd0);
        chk("rst wdata", mem_wdata_o, 32'd0);
        chk("rst load",  load_data_o, 32'd0);
        chk("rst err",   32'(err_o), 32'd0);
        chk("rst code",  32'(err_code_o), 32'd0);

        foreach (vq[i]) run_vec(vq[i]);

        // Busy stage: a stray valid_i during REQ must not be taken.
        @(negedge clk);
        valid_i = 1'b1; opcode_i = LOAD; funct3_i = 3'd2; addr_i = 32'h400;
        @(negedge clk);
        chk("busy ready1", 32'(ready_o), 32'd0);
        chk("busy req1", 32'(mem_req_o), 32'd1);
        opcode_i = ALU;
        @(negedge clk);
        chk("busy ready2", 32'(ready_o), 32'd0);
        chk("busy valid2", 32'(valid_o), 32'd0);
        valid_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h11223344;
        @(negedge clk);
        mem_ack_i = 1'b0;
        chk("busy valid3", 32'(valid_o), 32'd1);
        chk("busy load3", load_data_o, 32'h11223344);
        chk("busy ready3", 32'(ready_o), 32'd0);
        @(negedge clk);
        chk("busy valid4", 32'(valid_o), 32'd0);
        chk("busy ready4", 32'(ready_o), 32'd1);
        @(negedge clk);
        chk("busy no_stray", 32'(valid_o), 32'd0);
        chk("busy hold", load_data_o, 32'h11223344);

        // Reset during the second REQ cycle, late ack afterwards.
        valid_i = 1'b1; opcode_i = LOAD; funct3_i = 3'd2; addr_i = 32'h500;
        @(negedge clk);
        valid_i = 1'b0;
        chk("rmid req1", 32'(mem_req_o), 32'd1);
        @(negedge clk);
        chk("rmid req2", 32'(mem_req_o), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mem_ack_i = 1'b1;
        chk("rmid req_off", 32'(mem_req_o), 32'd0);
        chk("rmid ready", 32'(ready_o), 32'd1);
        chk("rmid valid", 32'(valid_o), 32'd0);
        @(negedge clk);
        mem_ack_i = 1'b0;
        chk("rmid ack_ign_valid", 32'(valid_o), 32'd0);
        chk("rmid ack_ign_req", 32'(mem_req_o), 32'd0);
        valid_i = 1'b1; opcode_i = ALU;
        @(negedge clk);
        valid_i = 1'b0;
        chk("rmid add_valid", 32'(valid_o), 32'd1);
        chk("rmid add_err", 32'(err_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
